seq_alu_core: RTL and testbench

- Parametrised, handshaked successor to the team's combinational 8-bit arithmetic/compare cells.
- Operations: add, subtract, multiply, divide/modulo and unsigned compare, on WIDTH-bit operands behind valid/ready on both sides.
- Add, subtract and compare complete in one cycle; multiply (shift-add) and divide (restoring) iterate one bit per cycle to keep area low.
- Sits between the instruction decoder and the register writeback stage.

---
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu_core.sv | 99 +++++++++
 tb/tb_seq_alu_core.sv | 115 +++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the decoder, seq_alu_core and writeback
interface seq_alu_if #(parameter int WIDTH = 8);
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 flag_carry;
   logic                 flag_zero;
   logic                 flag_dbz;
   logic                 flag_err;
   logic                 busy;
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, flag_carry, flag_zero, flag_dbz, flag_err, busy
   );
   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, flag_carry, flag_zero, flag_dbz, flag_err, busy
   );
endinterface

// File: rtl/seq_alu_core.sv
// seq_alu_core: handshaked unsigned ALU, one-cycle add/sub/compare, bit-serial multiply and restoring divide
module seq_alu_core #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic      clk,
   input logic      rst,
   seq_alu_if.slave bus
);
   localparam int W = WIDTH;
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     b_q, b_d;
   logic [2*W-1:0]   acc_q, acc_d, res_q, res_d;
   logic             carry_q, carry_d, zero_q, zero_d, dbz_q, dbz_d, err_q, err_d;
   logic [W:0]       sum, diff, msum, shl;
   logic             accept;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         dbz_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         dbz_q   <= dbz_d;
         err_q   <= err_d;
      end
   end
   // acc holds {partial product high, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      accept  = bus.in_valid && state_q == IDLE;
      sum     = {1'b0, bus.a} + {1'b0, bus.b};
      diff    = {1'b0, bus.a} - {1'b0, bus.b};
      msum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, acc_q[0] ? b_q : {W{1'b0}}};
      shl     = {acc_q[2*W-1:W], acc_q[W-1]};
      state_d = state_q;
      cnt_d   = cnt_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res_d   = res_q;
      carry_d = carry_q;
      dbz_d   = dbz_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (accept) begin
            b_d     = bus.b;
            acc_d   = {{W{1'b0}}, bus.a};
            cnt_d   = CNT_W'(W);
            carry_d = 1'b0;
            dbz_d   = 1'b0;
            err_d   = 1'b0;
            state_d = DONE;
            case (bus.op)
               3'd0: begin res_d = {{(W-1){1'b0}}, sum}; carry_d = sum[W]; end
               3'd1: begin res_d = {{W{1'b0}}, diff[W-1:0]}; carry_d = diff[W]; end
               3'd2: state_d = MUL;
               3'd3: if (bus.b == '0) begin res_d = '0; dbz_d = 1'b1; end else state_d = DIV;
               3'd4: res_d = {{(2*W-1){1'b0}}, bus.a == bus.b};
               3'd5: res_d = {{(2*W-1){1'b0}}, bus.a > bus.b};
               3'd6: res_d = {{(2*W-1){1'b0}}, bus.a < bus.b};
               default: begin res_d = '0; err_d = 1'b1; end
            endcase
         end
         MUL, DIV: begin
            acc_d = state_q == MUL ? {msum, acc_q[W-1:1]} :
                    shl >= {1'b0, b_q} ? {W'(shl - {1'b0, b_q}), acc_q[W-2:0], 1'b1} :
                    {shl[W-1:0], acc_q[W-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               res_d   = acc_d;
            end
         end
         default: if (bus.out_ready) state_d = IDLE;
      endcase
      zero_d = res_d == '0;
   end
   assign bus.in_ready   = state_q == IDLE;
   assign bus.out_valid  = state_q == DONE;
   assign bus.busy       = state_q != IDLE;
   assign bus.result     = res_q;
   assign bus.flag_carry = carry_q;
   assign bus.flag_zero  = zero_q;
   assign bus.flag_dbz   = dbz_q;
   assign bus.flag_err   = err_q;
endmodule

// File: tb/tb_seq_alu_core.sv
// tb_seq_alu_core: directed and randomized checks of seq_alu_core against an arithmetic reference model
module tb_seq_alu_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   seq_alu_if #(.WIDTH(8)) bus ();
   seq_alu_core #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask
   // returns {carry, zero, dbz, err, result[15:0]}
   function automatic logic [19:0] model(input logic [2:0] o, input int unsigned x, input int unsigned y);
      int unsigned r = 0;
      logic c = 1'b0, d = 1'b0, e = 1'b0;
      case (o)
         3'd0: begin r = x + y; c = r > 255; end
         3'd1: begin r = (256 + x - y) % 256; c = x < y; end
         3'd2: r = x * y;
         3'd3: if (y == 0) d = 1'b1; else r = (x % y) * 256 + x / y;
         3'd4: r = (x == y) ? 1 : 0;
         3'd5: r = (x > y) ? 1 : 0;
         3'd6: r = (x < y) ? 1 : 0;
         default: e = 1'b1;
      endcase
      return {c, r == 0, d, e, 16'(r)};
   endfunction
   task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int stall);
      logic [19:0] exp;
      int lat;
      exp = model(o, x, y);
      @(negedge clk);
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.op = o;
      bus.a = x;
      bus.b = y;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op = 3'($urandom);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         check("busy_mid", {30'd0, bus.busy, bus.in_ready}, 32'b10);
         @(negedge clk);
         bus.a = 8'($urandom);
         bus.b = 8'($urandom);
         lat++;
      end
      check("latency", 32'(lat), (o == 3'd2 || (o == 3'd3 && y != 0)) ? 32'd9 : 32'd1);
      check("result", 32'(bus.result), 32'(exp[15:0]));
      check("flags", {28'd0, bus.flag_carry, bus.flag_zero, bus.flag_dbz, bus.flag_err}, 32'(exp[19:16]));
      repeat (stall) begin
         bus.in_valid = 1'($urandom);
         bus.op = 3'($urandom);
         @(negedge clk);
         check("stall_hold", {bus.out_valid, bus.in_ready, bus.flag_carry, bus.flag_zero, bus.flag_dbz, bus.flag_err, 10'd0, bus.result},
               {2'b10, exp[19:16], 10'd0, exp[15:0]});
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("release", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.op = '0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {bus.in_ready, bus.out_valid, bus.busy, bus.flag_carry, bus.flag_zero, bus.flag_dbz, bus.flag_err, 9'd0, bus.result},
            {1'b1, 31'd0});
      rst = 1'b0;
      do_op(3'd0, 8'd200, 8'd100, 0);
      do_op(3'd2, 8'd255, 8'd255, 0);
      do_op(3'd3, 8'd200, 8'd7, 0);
      do_op(3'd3, 8'd5, 8'd0, 0);
      do_op(3'd1, 8'd3, 8'd5, 5);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = 3'd2;
      bus.a = 8'd13;
      bus.b = 8'd11;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_reset", {bus.out_valid, bus.in_ready, bus.busy, 13'd0, bus.result}, {3'b010, 29'd0});
      do_op(3'd5, 8'h80, 8'h7F, 0);
      do_op(3'd7, 8'h12, 8'h34, 0);
      do_op(3'd4, 8'h5A, 8'h5A, 0);
      do_op(3'd2, 8'd0, 8'd77, 0);
      do_op(3'd3, 8'd3, 8'd200, 0);
      do_op(3'd1, 8'd9, 8'd9, 1);
      for (int i = 0; i < 200; i++) begin
         logic [7:0] x, y;
         x = 8'($urandom);
         y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         do_op(3'($urandom), x, y, int'($urandom_range(0, 3)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
